// File: rtl/cpu_run_controller_pkg.sv
// cpu_run_controller_pkg: controller state encoding and register-file init-mode codes
package cpu_run_controller_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_RSTHOLD, ST_RUN, ST_DUMP, ST_DONE} state_e;
  localparam logic [1:0] INIT_INDEX = 2'd0;
  localparam logic [1:0] INIT_ZERO  = 2'd1;
  localparam logic [1:0] INIT_VALUE = 2'd2;
  localparam logic [1:0] INIT_RSVD  = 2'd3;
endpackage

// File: rtl/cpu_run_controller_halt_detector.sv
// halt_detector: flags a halt once pc (in: clock, reset, en, pc) repeats HALT_STABLE consecutive times (out: halt)
module halt_detector #(
  parameter int DATA_WIDTH  = 32,
  parameter int HALT_STABLE = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  halt
);
  localparam int SW = $clog2(HALT_STABLE + 1);
  logic [DATA_WIDTH-1:0] prev_pc_q, prev_pc_d;
  logic                  have_prev_q, have_prev_d;
  logic [SW-1:0]         stable_q, stable_d;
  always_comb begin
    prev_pc_d   = pc;
    have_prev_d = en;
    stable_d    = (en && have_prev_q && pc == prev_pc_q) ? stable_q + SW'(1) : '0;
    halt        = en && stable_d == SW'(HALT_STABLE);
  end
  always_ff @(posedge clock)
    if (reset) begin
      prev_pc_q   <= '0;
      have_prev_q <= 1'b0;
      stable_q    <= '0;
    end else begin
      prev_pc_q   <= prev_pc_d;
      have_prev_q <= have_prev_d;
      stable_q    <= stable_d;
    end
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: preloads the RF, holds/runs the CPU until halt or timeout, then streams every register out over valid/ready
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1024,
  parameter int HALT_STABLE  = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            init_mode,
  input  logic [DATA_WIDTH-1:0] init_value,
  output logic                  cpu_reset_n,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  rf_owner,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  input  logic                  dump_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count
);
  localparam int IW = ADDR_WIDTH + 1;
  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  timeout_q, timeout_d;
  logic                  dump_valid_q, dump_valid_d;
  logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
  logic                  halt;
  halt_detector #(.DATA_WIDTH(DATA_WIDTH), .HALT_STABLE(HALT_STABLE)) u_halt (
    .clock (clock),
    .reset (reset),
    .en    (state_q == ST_RUN),
    .pc    (pc),
    .halt  (halt)
  );
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cycle_count_d = cycle_count_q;
    mode_d        = mode_q;
    value_d       = value_q;
    timeout_d     = timeout_q;
    dump_valid_d  = dump_valid_q;
    dump_addr_d   = dump_addr_q;
    dump_data_d   = dump_data_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d       = ST_INIT;
        idx_d         = '0;
        cycle_count_d = '0;
        timeout_d     = 1'b0;
        mode_d        = init_mode;
        value_d       = init_value;
      end
      ST_INIT: begin
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NUM_REGS - 1)) begin
          state_d = ST_RSTHOLD;
          idx_d   = '0;
        end
      end
      ST_RSTHOLD: begin
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(RESET_CYCLES - 1)) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        cycle_count_d = &cycle_count_q ? cycle_count_q : cycle_count_q + CNT_WIDTH'(1);
        if (halt || cycle_count_d == CNT_WIDTH'(MAX_CYCLES)) begin
          state_d   = ST_DUMP;
          timeout_d = !halt;
        end
      end
      ST_DUMP: begin
        if (dump_valid_q && dump_ready) dump_valid_d = 1'b0;
        if ((!dump_valid_q || dump_ready) && idx_q != IW'(NUM_REGS)) begin
          dump_valid_d = 1'b1;
          dump_addr_d  = idx_q[ADDR_WIDTH-1:0];
          dump_data_d  = rf_rd_data;
          idx_d        = idx_q + IW'(1);
        end else if (dump_valid_q && dump_ready) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cycle_count_q <= '0;
      mode_q        <= INIT_INDEX;
      value_q       <= '0;
      timeout_q     <= 1'b0;
      dump_valid_q  <= 1'b0;
      dump_addr_q   <= '0;
      dump_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cycle_count_q <= cycle_count_d;
      mode_q        <= mode_d;
      value_q       <= value_d;
      timeout_q     <= timeout_d;
      dump_valid_q  <= dump_valid_d;
      dump_addr_q   <= dump_addr_d;
      dump_data_q   <= dump_data_d;
    end
  assign cpu_reset_n = state_q == ST_RUN;
  assign rf_wr_en    = state_q == ST_INIT;
  assign rf_owner    = rf_wr_en || state_q == ST_DUMP;
  assign busy        = state_q != ST_IDLE && state_q != ST_DONE;
  assign done        = state_q == ST_DONE;
  assign rf_wr_addr  = rf_wr_en ? idx_q[ADDR_WIDTH-1:0] : '0;
  assign rf_wr_data  = !rf_wr_en ? '0 : mode_q == INIT_ZERO ? '0 : mode_q == INIT_VALUE ? value_q : DATA_WIDTH'(idx_q);
  assign rf_rd_addr  = state_q == ST_DUMP ? idx_q[ADDR_WIDTH-1:0] : '0;
  assign dump_valid  = dump_valid_q;
  assign dump_addr   = dump_addr_q;
  assign dump_data   = dump_data_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: randomized run-controller bench with a timeline-level reference model
module tb_cpu_run_controller;
  localparam int N = 32, R = 2, MAXC = 8, HS = 3;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, dump_ready = 1'b1;
  logic [1:0]  init_mode = 2'd0;
  logic [31:0] init_value = '0, pc, rf_wr_data, rf_rd_data, dump_data;
  logic        cpu_reset_n, rf_owner, rf_wr_en, dump_valid, busy, done, timeout;
  logic [4:0]  rf_wr_addr, rf_rd_addr, dump_addr;
  logic [15:0] cycle_count;
  logic [31:0] rf [N];
  bit          halts = 1'b0;
  logic [31:0] hp = '0;
  int          ready_mode = 0, rp = 0;
  int          tests = 0, fails = 0;
  bit          pin_en = 1'b0, pin_to = 1'b0;
  int          pin_cc = 0, pin_i0 = 0, pin_i1 = 0;
  logic [31:0] pin_d0 = '0, pin_d1 = '0;
  cpu_run_controller #(.MAX_CYCLES(MAXC)) dut (
    .clock(clk), .reset(reset), .start(start), .init_mode(init_mode), .init_value(init_value),
    .cpu_reset_n(cpu_reset_n), .pc(pc), .rf_owner(rf_owner), .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data), .dump_ready(dump_ready),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) pc <= !cpu_reset_n ? 32'd0 : (halts && pc == hp) ? pc : pc + 32'd4;
  always @(posedge clk)
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    else if (cpu_reset_n) rf[{2'b01, pc[4:2]}] <= pc ^ 32'hA5A5_0000;
  assign rf_rd_data = rf_rd_addr == 5'd0 ? 32'd0 : rf[rf_rd_addr];
  function automatic logic [31:0] init_word(input logic [1:0] md, input int i, input logic [31:0] v);
    return md == 2'd1 ? 32'd0 : md == 2'd2 ? v : 32'(i);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  bit          active = 1'b0, fin = 1'b0, last_to = 1'b0, run_to = 1'b0;
  int          t = 0, L = 0, b = 0, last_cc = 0;
  logic [1:0]  m_mode = '0;
  logic [31:0] m_val = '0;
  logic [31:0] exp_reg [N];
  logic [31:0] beat_data [N];
  always @(negedge clk) begin : cmp
    logic e_rstn, e_busy, e_owner, e_wen, e_valid, e_done, e_to;
    int e_cc, d, k0;
    logic [31:0] p;
    e_rstn = 0; e_busy = 0; e_owner = 0; e_wen = 0; e_valid = 0; e_done = 0; e_to = 0; e_cc = 0;
    if (!active) begin
      e_done = fin; e_to = last_to; e_cc = last_cc;
    end else if (t <= N) begin
      e_busy = 1; e_owner = 1; e_wen = 1;
    end else if (t <= N + R) e_busy = 1;
    else if (t <= N + R + L) begin
      e_busy = 1; e_rstn = 1; e_cc = t - N - R - 1;
    end else begin
      d = t - N - R - L - 1;
      e_busy = 1; e_owner = 1; e_cc = L; e_to = run_to; e_valid = d >= 1;
    end
    chk("cpu_reset_n", 32'(cpu_reset_n), 32'(e_rstn));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("rf_owner", 32'(rf_owner), 32'(e_owner));
    chk("rf_wr_en", 32'(rf_wr_en), 32'(e_wen));
    chk("dump_valid", 32'(dump_valid), 32'(e_valid));
    chk("done", 32'(done), 32'(e_done));
    chk("timeout", 32'(timeout), 32'(e_to));
    chk("cycle_count", 32'(cycle_count), 32'(e_cc));
    if (e_wen) begin
      chk("rf_wr_addr", 32'(rf_wr_addr), 32'(t - 1));
      chk("rf_wr_data", rf_wr_data, init_word(m_mode, t - 1, m_val));
    end
    if (e_valid) begin
      chk("dump_addr", 32'(dump_addr), 32'(b));
      chk("dump_data", dump_data, exp_reg[b]);
    end
    if (reset) begin
      active = 0; fin = 0; last_cc = 0; last_to = 0;
    end else if (!active) begin
      if (start) begin
        active = 1; fin = 0; t = 1; b = 0; last_cc = 0; last_to = 0;
        m_mode = init_mode; m_val = init_value;
        k0 = halts ? int'(hp) / 4 + 1 : 0;
        if (halts && k0 + HS <= MAXC) begin L = k0 + HS; run_to = 0; end
        else begin L = MAXC; run_to = 1; end
        for (int i = 0; i < N; i++) exp_reg[i] = init_word(m_mode, i, m_val);
        for (int k = 1; k <= L; k++) begin
          p = (halts && 32'(4 * (k - 1)) > hp) ? hp : 32'(4 * (k - 1));
          exp_reg[{2'b01, p[4:2]}] = p ^ 32'hA5A5_0000;
        end
        exp_reg[0] = 32'd0;
      end
    end else begin
      if (e_valid && dump_ready) begin
        beat_data[b] = dump_data;
        b++;
        if (b == N) begin
          active = 0; fin = 1; last_cc = L; last_to = run_to;
          if (pin_en) begin
            chk("pin_run_len", 32'(L), 32'(pin_cc));
            chk("pin_cycle_count", 32'(cycle_count), 32'(pin_cc));
            chk("pin_timeout", 32'(timeout), 32'(pin_to));
            chk("pin_beat_a", beat_data[pin_i0], pin_d0);
            chk("pin_beat_b", beat_data[pin_i1], pin_d1);
          end
        end
      end
      t++;
    end
  end
  initial forever begin
    @(posedge clk); #1;
    rp++;
    dump_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (rp % 4 == 0 || rp % 4 == 3) : 1'($urandom_range(0, 1));
  end
  task automatic wait_cycles_until_run();
    int n = 0;
    while (!cpu_reset_n) begin
      @(posedge clk); #1;
      if (++n > 500) begin $display("FAIL run_wait: cpu_reset_n never rose"); $fatal(1); end
    end
  endtask
  task automatic do_run(input logic [1:0] md, input logic [31:0] v, input bit hl, input logic [31:0] h, input int rm, input bit poke);
    int n = 0;
    @(posedge clk); #1;
    init_mode = md; init_value = v; halts = hl; hp = h; ready_mode = rm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      wait_cycles_until_run();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (!done) begin
      @(posedge clk); #1;
      if (++n > 2000) begin $display("FAIL done_wait: done never asserted"); $fatal(1); end
    end
  endtask
  task automatic set_pins(input int cc, input bit to, input int i0, input logic [31:0] d0, input int i1, input logic [31:0] d1);
    pin_en = 1'b1; pin_cc = cc; pin_to = to; pin_i0 = i0; pin_d0 = d0; pin_i1 = i1; pin_d1 = d1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    set_pins(7, 1'b0, 20, 32'd20, 9, 32'hA5A5_0004);
    do_run(2'd0, 32'd0, 1'b1, 32'h0C, 0, 1'b0);
    set_pins(8, 1'b1, 5, 32'hDEAD_BEEF, 9, 32'hA5A5_0004);
    do_run(2'd2, 32'hDEAD_BEEF, 1'b0, 32'd0, 0, 1'b1);
    set_pins(8, 1'b0, 3, 32'd0, 12, 32'hA5A5_0010);
    do_run(2'd1, 32'h1234_5678, 1'b1, 32'h10, 1, 1'b0);
    pin_en = 1'b0;
    @(posedge clk); #1;
    halts = 1'b0; init_mode = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cycles_until_run();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    do_run(2'd3, 32'hCAFE_F00D, 1'b1, 32'h04, 2, 1'b0);
    for (int i = 0; i < 10; i++)
      do_run(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 7)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
